// File: rtl/mult_pkg.sv
// Shared definitions for the iterative multiplier family.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mult_state_t;

  // Counter must hold 0..WIDTH-1 with headroom for the last-iteration compare.
  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/mult_addsub_row.sv
// One partial-product row: adds or subtracts the multiplicand onto the accumulator high part.
module mult_addsub_row
  import mult_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH:0]   high,
  input  logic [WIDTH-1:0] mcand,
  input  logic             is_signed,
  input  logic             add_en,
  input  logic             sub,
  output logic [WIDTH:0]   sum,
  output logic             shift_in
);

  logic [WIDTH:0]   mext;
  logic [WIDTH:0]   operand;
  logic [WIDTH+1:0] full;

  always_comb begin
    mext    = is_signed ? {mcand[WIDTH-1], mcand} : {1'b0, mcand};
    operand = sub ? ~mext : mext;
    full    = {1'b0, high} + {1'b0, operand} + {{(WIDTH+1){1'b0}}, sub};
    if (add_en) begin
      sum = full[WIDTH:0];
    end else begin
      sum = high;
    end
    // Signed rows shift in the sign of the W+1-bit sum; unsigned rows shift in the carry.
    if (is_signed) begin
      shift_in = sum[WIDTH];
    end else begin
      shift_in = add_en ? full[WIDTH+1] : 1'b0;
    end
  end

endmodule

// File: rtl/iter_array_multiplier.sv
// Multi-cycle radix-2 shift-add multiplier with valid/ready handshakes on both sides.
module iter_array_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               is_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] prod
);

  localparam int CNT_W = cnt_width(WIDTH);

  mult_state_t      state, state_next;
  logic [CNT_W-1:0] cnt;
  logic [2*WIDTH:0] acc;
  logic [2*WIDTH:0] acc_step;
  logic [WIDTH-1:0] mcand;
  logic             sgn;
  logic             last;
  logic             accept;
  logic [WIDTH:0]   row_sum;
  logic             row_shift_in;

  assign last   = (cnt == CNT_W'(WIDTH - 1));
  assign accept = in_valid & in_ready;

  mult_addsub_row #(
    .WIDTH(WIDTH)
  ) u_row (
    .high      (acc[2*WIDTH:WIDTH]),
    .mcand     (mcand),
    .is_signed (sgn),
    .add_en    (acc[0]),
    .sub       (sgn & last),
    .sum       (row_sum),
    .shift_in  (row_shift_in)
  );

  assign acc_step = {row_shift_in, row_sum, acc[WIDTH-1:1]};

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = RUN;
      RUN:     if (last) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      prod      <= '0;
      cnt       <= '0;
      acc       <= '0;
      mcand     <= '0;
      sgn       <= 1'b0;
    end else begin
      state     <= state_next;
      in_ready  <= (state_next == IDLE);
      out_valid <= (state_next == DONE);
      if (state == IDLE && accept) begin
        mcand <= a;
        sgn   <= is_signed;
        acc   <= {{(WIDTH+1){1'b0}}, b};
        cnt   <= '0;
      end else if (state == RUN) begin
        acc <= acc_step;
        if (last) begin
          prod <= acc_step[2*WIDTH-1:0];
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_iter_array_multiplier.sv
// Scoreboard bench for iter_array_multiplier at WIDTH=4 and WIDTH=8.
module tb_iter_array_multiplier;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        v4, r4, s4, ov4, or4;
  logic [3:0]  a4, b4;
  logic [7:0]  p4;
  logic        v8, r8, s8, ov8, or8;
  logic [7:0]  a8, b8;
  logic [15:0] p8;

  iter_array_multiplier #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(v4), .in_ready(r4), .a(a4), .b(b4),
    .is_signed(s4), .out_valid(ov4), .out_ready(or4), .prod(p4)
  );

  iter_array_multiplier #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(v8), .in_ready(r8), .a(a8), .b(b8),
    .is_signed(s8), .out_valid(ov8), .out_ready(or8), .prod(p8)
  );

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  logic [7:0]  exp4[$];
  logic [15:0] exp8[$];
  int unsigned acc8_hist[$];
  int unsigned acc_cyc4 = 0;
  int unsigned acc_cyc8 = 0;
  logic pv4 = 1'b0;
  logic pv8 = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  function automatic logic [7:0] ref4(input logic [3:0] x, input logic [3:0] y, input logic s);
    logic signed [7:0] xs, ys;
    logic [7:0] xu, yu;
    xs = $signed(x);
    ys = $signed(y);
    xu = {4'h0, x};
    yu = {4'h0, y};
    if (s) return xs * ys;
    return xu * yu;
  endfunction

  // Monitor: latency counted from the accept cycle (cycle 0) to the first cycle out_valid is high.
  always @(negedge clk) begin
    if (!rst) begin
      if (ov4 && !pv4) check("latency4", cyc - acc_cyc4, 5);
      if (ov4 && or4) begin
        if (exp4.size() == 0) check("unexpected_result4", {24'h0, p4}, 32'hFFFF_FFFF);
        else check("prod4", {24'h0, p4}, {24'h0, exp4.pop_front()});
      end
      if (ov8 && !pv8) check("latency8", cyc - acc_cyc8, 9);
      if (ov8 && or8) begin
        if (exp8.size() == 0) check("unexpected_result8", {16'h0, p8}, 32'hFFFF_FFFF);
        else check("prod8", {16'h0, p8}, {16'h0, exp8.pop_front()});
      end
    end
    pv4 <= ov4;
    pv8 <= ov8;
  end

  // Issues one op; keeps in_valid high with junk operands while busy to show it is ignored.
  task automatic op4(input logic [3:0] x, input logic [3:0] y, input logic s, input logic [7:0] e);
    int unsigned n = 0;
    @(negedge clk);
    a4 = x; b4 = y; s4 = s; v4 = 1'b1;
    while (!r4 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!r4) begin
      check("accept_timeout4", 0, 1);
      v4 = 1'b0;
      return;
    end
    exp4.push_back(e);
    acc_cyc4 = cyc;
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      a4 = 4'($urandom);
      b4 = 4'($urandom);
      s4 = 1'($urandom);
      @(negedge clk);
    end
    v4 = 1'b0;
  endtask

  task automatic op8(input logic [7:0] x, input logic [7:0] y, input logic s, input logic [15:0] e);
    int unsigned n = 0;
    @(negedge clk);
    a8 = x; b8 = y; s8 = s; v8 = 1'b1;
    while (!r8 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!r8) begin
      check("accept_timeout8", 0, 1);
      v8 = 1'b0;
      return;
    end
    exp8.push_back(e);
    acc_cyc8 = cyc;
    acc8_hist.push_back(cyc);
    @(posedge clk);
    #1 v8 = 1'b0;
  endtask

  initial begin
    int unsigned n;
    rst = 1'b1;
    v4 = 1'b0; a4 = '0; b4 = '0; s4 = 1'b0; or4 = 1'b1;
    v8 = 1'b0; a8 = '0; b8 = '0; s8 = 1'b0; or8 = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_in_ready4", {31'h0, r4}, 1);
    check("reset_out_valid4", {31'h0, ov4}, 0);
    check("reset_prod4", {24'h0, p4}, 0);
    check("reset_in_ready8", {31'h0, r8}, 1);
    check("reset_out_valid8", {31'h0, ov8}, 0);
    check("reset_prod8", {16'h0, p8}, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Backpressure: 15*15 held in DONE for 10 cycles.
    or4 = 1'b0;
    op4(4'd15, 4'd15, 1'b0, 8'hE1);
    n = 0;
    while (!ov4 && n < 20) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 10; i++) begin
      check("bp_out_valid", {31'h0, ov4}, 1);
      check("bp_prod", {24'h0, p4}, 32'hE1);
      check("bp_in_ready", {31'h0, r4}, 0);
      @(negedge clk);
    end
    @(posedge clk);
    #1 or4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("hold_prod_after_hs", {24'h0, p4}, 32'hE1);
    check("idle_out_valid", {31'h0, ov4}, 0);
    check("idle_in_ready", {31'h0, r4}, 1);

    op4(4'h8, 4'h8, 1'b1, 8'h40);
    op4(4'h8, 4'h7, 1'b1, 8'hC8);
    op4(4'h7, 4'hF, 1'b1, 8'hF9);

    // Reset in RUN cycle 2 drops the op.
    @(negedge clk);
    a4 = 4'd5; b4 = 4'd3; s4 = 1'b0; v4 = 1'b1;
    @(posedge clk);
    #1 v4 = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_mid_in_ready", {31'h0, r4}, 1);
    check("rst_mid_out_valid", {31'h0, ov4}, 0);
    check("rst_mid_prod", {24'h0, p4}, 0);
    repeat (6) @(negedge clk);
    check("rst_mid_no_result", {31'h0, ov4}, 0);
    op4(4'd3, 4'd5, 1'b0, 8'd15);

    for (int s = 0; s < 2; s++)
      for (int x = 0; x < 16; x++)
        for (int y = 0; y < 16; y++)
          op4(4'(x), 4'(y), 1'(s), ref4(4'(x), 4'(y), 1'(s)));

    op8(8'd255, 8'd255, 1'b0, 16'd65025);
    op8(8'h80, 8'h80, 1'b1, 16'd16384);
    op8(8'h80, 8'h7F, 1'b1, 16'hC080);
    if (acc8_hist.size() == 3) begin
      check("spacing8_a", acc8_hist[1] - acc8_hist[0], 10);
      check("spacing8_b", acc8_hist[2] - acc8_hist[1], 10);
    end else begin
      check("accepts8", acc8_hist.size(), 3);
    end

    n = 0;
    while ((exp4.size() != 0 || exp8.size() != 0) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("drain4", exp4.size(), 0);
    check("drain8", exp8.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
